// File: rtl/wb_surf_fanout.sv
// Wishbone fan-out from one master to NCHAN slaves with decode, disabled-channel, master-abort and optional WB_SURF_FANOUT_TIMEOUT_EN timeout.
// Latency: request to slave strobe 1 cycle, slave ack/err to master ack/err 1 cycle, decode/disabled error 1 cycle.
// Backpressure: master holds stb until ack/err; slave wait is unbounded unless WB_SURF_FANOUT_TIMEOUT_EN is defined.
module wb_surf_fanout #(
    parameter int NCHAN      = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_LSB    = 6,
    parameter int SEL_BITS   = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic                             wb_cyc_i,
    input  logic                             wb_stb_i,
    input  logic                             wb_we_i,
    input  logic [ADDR_WIDTH-1:0]            wb_adr_i,
    input  logic [DATA_WIDTH-1:0]            wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]          wb_sel_i,
    output logic                             wb_ack_o,
    output logic                             wb_err_o,
    output logic                             wb_rty_o,
    output logic [DATA_WIDTH-1:0]            wb_dat_o,
    input  logic [NCHAN-1:0]                 chan_en_i,
    output logic [NCHAN-1:0]                 m_cyc_o,
    output logic [NCHAN-1:0]                 m_stb_o,
    output logic [NCHAN-1:0]                 m_we_o,
    output logic [NCHAN*ADDR_WIDTH-1:0]      m_adr_o,
    output logic [NCHAN*DATA_WIDTH-1:0]      m_dat_o,
    output logic [NCHAN*DATA_WIDTH/8-1:0]    m_sel_o,
    input  logic [NCHAN-1:0]                 m_ack_i,
    input  logic [NCHAN-1:0]                 m_err_i,
    input  logic [NCHAN*DATA_WIDTH-1:0]      m_dat_i,
    output logic [15:0]                      timeout_cnt_o,
    output logic [3:0]                       last_err_chan_o
);

    if (NCHAN < 1 || NCHAN > 16 || SEL_BITS < 1 || TIMEOUT < 1 || TIMEOUT > 255 ||
        (DATA_WIDTH % 8) != 0 || SEL_LSB + SEL_BITS > ADDR_WIDTH) begin : g_param_err
        $error("wb_surf_fanout: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

    state_t                    state_q, state_d;
    logic [SEL_BITS-1:0]       req_k, k_q;
    logic [ADDR_WIDTH-1:0]     adr_q;
    logic [DATA_WIDTH-1:0]     dat_q, rdat_q, k_dat;
    logic [DATA_WIDTH/8-1:0]   sel_q;
    logic                      we_q;
    logic [NCHAN-1:0]          stb_q, req_onehot;
    logic                      req_vld, req_ok, k_ack, k_err;
    logic                      go_ack, go_err, timeout_hit;
    logic                      ack_q, err_q;
    logic [3:0]                last_err_q;

    assign req_vld = wb_cyc_i & wb_stb_i;
    assign req_k   = wb_adr_i[SEL_LSB +: SEL_BITS];

    // Index decode by loop so out-of-range select values simply match nothing.
    always_comb begin
        req_ok     = 1'b0;
        req_onehot = '0;
        k_ack      = 1'b0;
        k_err      = 1'b0;
        k_dat      = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (int'(req_k) == i) begin
                req_onehot[i] = 1'b1;
                req_ok        = chan_en_i[i];
            end
            if (int'(k_q) == i) begin
                k_ack = m_ack_i[i];
                k_err = m_err_i[i];
                k_dat = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        go_ack  = 1'b0;
        go_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    if (req_ok) begin
                        state_d = FWD;
                    end else begin
                        state_d = RESP;
                        go_err  = 1'b1;
                    end
                end
            end
            FWD: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (k_err) begin
                    state_d = RESP;
                    go_err  = 1'b1;
                end else if (k_ack) begin
                    state_d = RESP;
                    go_ack  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    go_err  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            k_q        <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            stb_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdat_q     <= '0;
            last_err_q <= '0;
        end else begin
            if (state_q == IDLE && req_vld) begin
                k_q   <= req_k;
                adr_q <= wb_adr_i;
                dat_q <= wb_dat_i;
                sel_q <= wb_sel_i;
                we_q  <= wb_we_i;
            end
            stb_q <= (state_d == FWD) ? ((state_q == IDLE) ? req_onehot : stb_q) : '0;
            ack_q <= go_ack;
            err_q <= go_err;
            if (go_ack)      rdat_q <= k_dat;
            else if (go_err) rdat_q <= '0;
            if (go_err) last_err_q <= (state_q == IDLE) ? 4'(req_k) : 4'(k_q);
        end
    end

`ifdef WB_SURF_FANOUT_TIMEOUT_EN
    logic [7:0]  wait_q;
    logic [15:0] to_cnt_q;
    logic        to_fire;

    // Wait count is 0 in the first FWD cycle, so expiry lands after TIMEOUT FWD cycles.
    assign timeout_hit = (state_q == FWD) && (wait_q == 8'(TIMEOUT - 1));
    assign to_fire     = timeout_hit & wb_cyc_i & ~k_ack & ~k_err;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wait_q   <= '0;
            to_cnt_q <= '0;
        end else begin
            wait_q <= (state_q == FWD) ? wait_q + 8'd1 : 8'd0;
            if (to_fire && to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    assign timeout_cnt_o = to_cnt_q;
`else
    assign timeout_hit   = 1'b0;
    assign timeout_cnt_o = '0;
`endif

    assign wb_ack_o        = ack_q;
    assign wb_err_o        = err_q;
    assign wb_rty_o        = 1'b0;
    assign wb_dat_o        = rdat_q;
    assign last_err_chan_o = last_err_q;

    assign m_cyc_o = stb_q;
    assign m_stb_o = stb_q;
    assign m_we_o  = {NCHAN{we_q}};
    assign m_adr_o = {NCHAN{adr_q}};
    assign m_dat_o = {NCHAN{dat_q}};
    assign m_sel_o = {NCHAN{sel_q}};

endmodule
